// File: rtl/pipe_stage_regs.sv
// Pipeline register stack for the 5-stage RV32I core: PC, IF/ID, ID/EX,
// EX/MEM and MEM/WB, with stall/flush controls from the hazard unit.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   StallF, StallD, FlushD, FlushE hazard controls (flush beats stall)
//   PCNextF, InstrF               fetch inputs      -> PCF
//   InstrD, PCD, PCPlus4D         IF/ID contents; Rs1D/Rs2D/RdD slices
//   *D decode fields (in)         -> *E ID/EX contents (out)
//   ALUResultE, WriteDataE        -> EX/MEM contents (*M out)
//   ReadDataM                     -> MEM/WB contents (*W out)
module pipe_stage_regs #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            FlushE,
  input  logic [XLEN-1:0] PCNextF,
  input  logic [31:0]     InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic [4:0]      RdD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [2:0]      ALUControlD,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic [XLEN-1:0] WriteDataE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RdM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  input  logic [XLEN-1:0] ReadDataM,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [4:0]      RdW,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW
);

  logic [XLEN-1:0] pcPlus4F;

  // Wraps modulo 2^XLEN by construction.
  assign pcPlus4F = PCF + XLEN'(4);

  assign Rs1D = InstrD[19:15];
  assign Rs2D = InstrD[24:20];
  assign RdD  = InstrD[11:7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PCF <= XLEN'(RESET_PC);
    end else if (!StallF) begin
      PCF <= PCNextF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
    end else if (FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
    end else if (!StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= pcPlus4F;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || FlushE) begin
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
    end else begin
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      ImmExtE     <= ImmExtD;
      RegWriteE   <= RegWriteD;
      MemWriteE   <= MemWriteD;
      JumpE       <= JumpD;
      BranchE     <= BranchD;
      ALUSrcE     <= ALUSrcD;
      ResultSrcE  <= ResultSrcD;
      ALUControlE <= ALUControlD;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= RdD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
    end else begin
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
    end else begin
      ALUResultW <= ALUResultM;
      ReadDataW  <= ReadDataM;
      PCPlus4W   <= PCPlus4M;
      RdW        <= RdM;
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
    end
  end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs: expected values are queued when the
// stimulus is driven and popped/compared once the registers have updated.
module tb_pipe_stage_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallF = 0, StallD = 0, FlushD = 0, FlushE = 0;
  logic [31:0] PCNextF = '0, InstrF = 32'h13;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [31:0] RD1D = '0, RD2D = '0, ImmExtD = '0;
  logic        RegWriteD = 0, MemWriteD = 0, JumpD = 0, BranchD = 0;
  logic        ALUSrcD = 0;
  logic [1:0]  ResultSrcD = '0;
  logic [2:0]  ALUControlD = '0;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [31:0] ALUResultE = '0, WriteDataE = '0;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ReadDataM = '0;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;

  always #5 clk = ~clk;

  pipe_stage_regs dut (
    .clk(clk), .rst(rst),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCNextF(PCNextF), .InstrF(InstrF), .PCF(PCF),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .ReadDataM(ReadDataM),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t expQ[$];
  int   nAssert = 0;
  int   nFail   = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    expQ.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    nAssert++;
    if (expQ.size() == 0) begin
      nFail++;
      $error("FAIL scoreboard_empty: observed %h required an entry", obs);
    end else begin
      e = expQ.pop_front();
      assert (obs === e.val) else begin
        nFail++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Fill the pipe with live state so the async reset has work to do.
    @(negedge clk);
    rst       = 1'b0;
    PCNextF   = 32'h100;
    InstrF    = 32'h00A00093;
    RegWriteD = 1'b1;
    ALUResultE = 32'hCAFE;
    repeat (4) step();

    // Reset between edges: outputs must clear before the next edge.
    #2 rst = 1'b1;
    push("rst_PCF", 32'h0);
    push("rst_InstrD", 32'h13);
    push("rst_RegWriteW", 32'h0);
    push("rst_RegWriteE", 32'h0);
    push("rst_ALUResultW", 32'h0);
    push("rst_RdD", 32'h0);
    #1;
    chk(PCF);
    chk(InstrD);
    chk(RegWriteW);
    chk(RegWriteE);
    chk(ALUResultW);
    chk(RdD);

    @(negedge clk);
    rst        = 1'b0;
    RegWriteD  = 1'b0;
    ALUResultE = '0;

    // Cycle A: fetch addi x1,x0,10 at PC 0.
    PCNextF = PCF + 32'd4;
    InstrF  = 32'h00A00093;
    push("A_PCF", 32'h4);
    push("A_InstrD", 32'h00A00093);
    push("A_PCD", 32'h0);
    push("A_PCPlus4D", 32'h4);
    push("A_RdD", 32'd1);
    step();
    chk(PCF); chk(InstrD); chk(PCD); chk(PCPlus4D); chk(RdD);

    // Cycle B: decode addi, fetch sw x2,0(x1) at PC 4.
    PCNextF     = PCF + 32'd4;
    InstrF      = 32'h0020A023;
    RegWriteD   = 1'b1;
    RD1D        = 32'h1111_2222;
    ImmExtD     = 32'd10;
    ALUSrcD     = 1'b1;
    ALUControlD = 3'b010;
    push("B_PCF", 32'h8);
    push("B_RdE", 32'd1);
    push("B_RegWriteE", 32'd1);
    push("B_PCPlus4E", 32'h4);
    push("B_RD1E", 32'h1111_2222);
    push("B_ImmExtE", 32'd10);
    push("B_ALUControlE", 32'd2);
    push("B_InstrD", 32'h0020A023);
    step();
    chk(PCF); chk(RdE); chk(RegWriteE); chk(PCPlus4E);
    chk(RD1E); chk(ImmExtE); chk(ALUControlE); chk(InstrD);

    // Cycle C: load-use stall with bubble into EX.
    StallF     = 1'b1;
    StallD     = 1'b1;
    FlushE     = 1'b1;
    PCNextF    = 32'hC;
    InstrF     = 32'h0000_0033;
    RegWriteD  = 1'b1;
    MemWriteD  = 1'b1;
    ALUResultE = 32'd10;
    push("C_PCF", 32'h8);
    push("C_InstrD", 32'h0020A023);
    push("C_RegWriteE", 32'd0);
    push("C_MemWriteE", 32'd0);
    push("C_RdE", 32'd0);
    push("C_RdM", 32'd1);
    push("C_RegWriteM", 32'd1);
    push("C_ALUResultM", 32'd10);
    push("C_PCPlus4M", 32'h4);
    step();
    chk(PCF); chk(InstrD); chk(RegWriteE); chk(MemWriteE); chk(RdE);
    chk(RdM); chk(RegWriteM); chk(ALUResultM); chk(PCPlus4M);

    // Cycle D: stall released, sw moves to EX.
    StallF     = 1'b0;
    StallD     = 1'b0;
    FlushE     = 1'b0;
    RegWriteD  = 1'b0;
    MemWriteD  = 1'b1;
    ALUResultE = '0;
    ReadDataM  = 32'h55;
    InstrF     = 32'h00208133;
    push("D_RdW", 32'd1);
    push("D_RegWriteW", 32'd1);
    push("D_ALUResultW", 32'd10);
    push("D_ReadDataW", 32'h55);
    push("D_RegWriteM", 32'd0);
    push("D_MemWriteE", 32'd1);
    push("D_Rs1E", 32'd1);
    push("D_Rs2E", 32'd2);
    push("D_PCF", 32'hC);
    push("D_RdD", 32'd2);
    step();
    chk(RdW); chk(RegWriteW); chk(ALUResultW); chk(ReadDataW);
    chk(RegWriteM); chk(MemWriteE); chk(Rs1E); chk(Rs2E); chk(PCF); chk(RdD);

    // Cycle E: the bubble reaches writeback.
    MemWriteD = 1'b0;
    ReadDataM = '0;
    PCNextF   = 32'h10;
    push("E_RegWriteW", 32'd0);
    push("E_RdW", 32'd0);
    step();
    chk(RegWriteW); chk(RdW);

    // Cycle F: taken branch flushes IF/ID and ID/EX.
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    PCNextF   = 32'h40;
    RegWriteD = 1'b1;
    JumpD     = 1'b1;
    BranchD   = 1'b1;
    push("F_InstrD", 32'h13);
    push("F_PCPlus4D", 32'h0);
    push("F_RegWriteE", 32'd0);
    push("F_JumpE", 32'd0);
    push("F_BranchE", 32'd0);
    push("F_RD1E", 32'd0);
    push("F_PCF", 32'h40);
    step();
    chk(InstrD); chk(PCPlus4D); chk(RegWriteE); chk(JumpE);
    chk(BranchE); chk(RD1E); chk(PCF);

    // Cycle G0: reload a real instruction.
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    RegWriteD = 1'b0;
    JumpD     = 1'b0;
    BranchD   = 1'b0;
    InstrF    = 32'h00A00093;
    PCNextF   = 32'h44;
    push("G0_InstrD", 32'h00A00093);
    step();
    chk(InstrD);

    // Cycle G: stall and flush together; flush wins on IF/ID.
    StallF  = 1'b1;
    StallD  = 1'b1;
    FlushD  = 1'b1;
    InstrF  = 32'hDEADBEEF;
    PCNextF = 32'h80;
    push("G_InstrD", 32'h13);
    push("G_PCF", 32'h44);
    step();
    chk(InstrD); chk(PCF);

    // PC wrap through the internal +4 adder.
    StallF  = 1'b0;
    StallD  = 1'b0;
    FlushD  = 1'b0;
    PCNextF = 32'hFFFF_FFFC;
    push("H_PCF", 32'hFFFF_FFFC);
    step();
    chk(PCF);
    PCNextF = 32'h0;
    push("I_PCPlus4D", 32'h0);
    push("I_PCD", 32'hFFFF_FFFC);
    step();
    chk(PCPlus4D); chk(PCD);

    if (expQ.size() != 0) begin
      nAssert++;
      nFail++;
      $error("FAIL scoreboard_left: observed %0d entries required 0",
             expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAssert, nFail);
    $finish;
  end

endmodule
